// File: rtl/misc_pkg.sv
// Shared scalar types used across the interrupt and host-interface blocks.
package misc_pkg;

    typedef logic [31:0] U32;
    typedef logic [63:0] U64;

endpackage : misc_pkg

// File: rtl/msix_pkg.sv
// MSI-X table entry layout, FSM encoding and limits shared by the message generator.
package msix_pkg;
    import misc_pkg::*;

    localparam int unsigned MSIX_MAX_VEC = 32;

    typedef struct packed {
        U64   addr;
        U32   data;
        logic mask;
    } msix_entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } msix_state_e;

endpackage : msix_pkg

// File: rtl/msix_msg_gen_if.sv
// Posted DW write channel from the MSI-X generator toward the host-memory write path.
interface msix_msg_gen_if
    import misc_pkg::*;
#(
    parameter int unsigned NUM_VEC = 8
);
    localparam int unsigned VEC_W = $clog2(NUM_VEC);

    logic             wr_valid;
    logic             wr_ready;
    U64               wr_addr;
    U32               wr_data;
    logic [VEC_W-1:0] wr_vec;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output wr_vec,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  wr_vec,
        output wr_ready
    );

endinterface : msix_msg_gen_if

// File: rtl/msix_rr_arb.sv
// Combinational round-robin picker: lowest requesting index at or above ptr, wrapping to 0.
module msix_rr_arb #(
    parameter  int unsigned NUM_VEC = 8,
    localparam int unsigned VEC_W   = $clog2(NUM_VEC)
) (
    input  logic [NUM_VEC-1:0] req,
    input  logic [VEC_W-1:0]   ptr,
    output logic               gnt_valid,
    output logic [VEC_W-1:0]   gnt_idx
);

    function automatic logic [VEC_W-1:0] wrap_idx(input logic [VEC_W-1:0] base, input int unsigned ofs);
        int unsigned sum;
        sum = (32'(base) + ofs) % NUM_VEC;
        return VEC_W'(sum);
    endfunction

    // First hit scanning upward from ptr wins; later hits are ignored.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NUM_VEC; k++) begin
            if (!gnt_valid && req[wrap_idx(ptr, k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = wrap_idx(ptr, k);
            end
        end
    end

endmodule : msix_rr_arb

// File: rtl/msix_msg_gen.sv
// MSI-X message generator: pending/mask tracking, round-robin vector selection and
// one posted DW write per granted vector, plus the software table-programming port.
module msix_msg_gen
    import misc_pkg::*;
    import msix_pkg::*;
#(
    parameter  int unsigned NUM_VEC = 8,
    localparam int unsigned VEC_W   = $clog2(NUM_VEC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_VEC-1:0] intr_req,
    input  logic               tbl_wr_en,
    input  logic [VEC_W-1:0]   tbl_wr_idx,
    input  U64                 tbl_wr_addr,
    input  U32                 tbl_wr_data,
    input  logic               tbl_wr_mask,
    msix_msg_gen_if.master     wr,
    output logic [NUM_VEC-1:0] pba,
    output logic               busy
);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_ISSUE = ISSUE;

    msix_entry_t        tbl [NUM_VEC];
    logic [NUM_VEC-1:0] mask_vec;
    logic [NUM_VEC-1:0] eligible;
    logic [NUM_VEC-1:0] clr;
    logic [NUM_VEC-1:0] pba_nxt;

    logic [0:0]         state;
    logic [0:0]         state_nxt;
    logic [VEC_W-1:0]   ptr;
    logic [VEC_W-1:0]   ptr_nxt;
    logic               gnt_valid;
    logic [VEC_W-1:0]   gnt_idx;
    logic               hs;

    logic               valid_q;
    logic               valid_nxt;
    U64                 addr_q;
    U64                 addr_nxt;
    U32                 data_q;
    U32                 data_nxt;
    logic [VEC_W-1:0]   vec_q;
    logic [VEC_W-1:0]   vec_nxt;
    logic               busy_nxt;

    assign wr.wr_valid = valid_q;
    assign wr.wr_addr  = addr_q;
    assign wr.wr_data  = data_q;
    assign wr.wr_vec   = vec_q;

    // Table storage; reset leaves every entry masked until software programs it.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_VEC; i++) begin
            if (rst) begin
                tbl[i] <= '{addr: '0, data: '0, mask: 1'b1};
            end else if (tbl_wr_en && (tbl_wr_idx == VEC_W'(i))) begin
                tbl[i] <= '{addr: tbl_wr_addr, data: tbl_wr_data, mask: tbl_wr_mask};
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_VEC; i++) begin
            mask_vec[i] = tbl[i].mask;
        end
    end

    assign eligible = pba & ~mask_vec;

    msix_rr_arb #(
        .NUM_VEC (NUM_VEC)
    ) u_arb (
        .req       (eligible),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Next-state, output latching, pending update and pointer advance.
    always_comb begin
        state_nxt = state;
        valid_nxt = valid_q;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        vec_nxt   = vec_q;
        hs        = 1'b0;
        clr       = '0;
        ptr_nxt   = ptr;

        case (state)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_nxt = ST_ISSUE;
                    valid_nxt = 1'b1;
                    addr_nxt  = tbl[gnt_idx].addr;
                    data_nxt  = tbl[gnt_idx].data;
                    vec_nxt   = gnt_idx;
                end
            end
            ST_ISSUE: begin
                if (wr.wr_ready) begin
                    hs        = 1'b1;
                    state_nxt = ST_IDLE;
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                valid_nxt = 1'b0;
            end
        endcase

        if (hs) begin
            clr     = NUM_VEC'(1) << vec_q;
            ptr_nxt = (vec_q == VEC_W'(NUM_VEC - 1)) ? '0 : vec_q + 1'b1;
        end

        // A request arriving in the handshake cycle survives the clear.
        pba_nxt  = (pba & ~clr) | intr_req;
        busy_nxt = (state_nxt == ST_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            pba     <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            vec_q   <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            pba     <= pba_nxt;
            valid_q <= valid_nxt;
            addr_q  <= addr_nxt;
            data_q  <= data_nxt;
            vec_q   <= vec_nxt;
            busy    <= busy_nxt;
        end
    end

endmodule : msix_msg_gen

// File: tb/tb_msix_msg_gen.sv
// Scoreboard bench for msix_msg_gen: expected writes queued at stimulus, checked at handshake.
module tb_msix_msg_gen;

    localparam int unsigned NV = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NV-1:0] intr_req = '0;
    logic          tbl_wr_en = 1'b0;
    logic [2:0]    tbl_wr_idx = '0;
    logic [63:0]   tbl_wr_addr = '0;
    logic [31:0]   tbl_wr_data = '0;
    logic          tbl_wr_mask = 1'b0;
    logic [NV-1:0] pba;
    logic          busy;

    msix_msg_gen_if #(.NUM_VEC(NV)) wr_if ();

    msix_msg_gen #(.NUM_VEC(NV)) dut (
        .clk         (clk),
        .rst         (rst),
        .intr_req    (intr_req),
        .tbl_wr_en   (tbl_wr_en),
        .tbl_wr_idx  (tbl_wr_idx),
        .tbl_wr_addr (tbl_wr_addr),
        .tbl_wr_data (tbl_wr_data),
        .tbl_wr_mask (tbl_wr_mask),
        .wr          (wr_if),
        .pba         (pba),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  vec;
        logic [63:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int idx, input logic [63:0] a, input logic [31:0] d, input logic m);
        tbl_wr_en   = 1'b1;
        tbl_wr_idx  = 3'(idx);
        tbl_wr_addr = a;
        tbl_wr_data = d;
        tbl_wr_mask = m;
        tick();
        tbl_wr_en   = 1'b0;
    endtask

    task automatic pulse(input logic [NV-1:0] v);
        intr_req = v;
        tick();
        intr_req = '0;
    endtask

    task automatic push(input int v, input logic [63:0] a, input logic [31:0] d);
        exp_t e;
        e.vec  = 3'(v);
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Every accepted write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && wr_if.wr_valid === 1'b1 && wr_if.wr_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("sb_extra_write", 64'(sb.size()), 64'd1);
            end else begin
                mon_e = sb.pop_front();
                check_eq("sb_vec",  64'(wr_if.wr_vec),  64'(mon_e.vec));
                check_eq("sb_addr", wr_if.wr_addr,      mon_e.addr);
                check_eq("sb_data", 64'(wr_if.wr_data), 64'(mon_e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_if.wr_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_valid", 64'(wr_if.wr_valid), 64'd0);
        check_eq("rst_addr",  wr_if.wr_addr,       64'd0);
        check_eq("rst_data",  64'(wr_if.wr_data),  64'd0);
        check_eq("rst_vec",   64'(wr_if.wr_vec),   64'd0);
        check_eq("rst_busy",  64'(busy),           64'd0);
        check_eq("rst_pba",   64'(pba),            64'd0);

        // Single unmasked vector, exact 2-cycle latency.
        prog(0, 64'h1, 32'h1234_5678, 1'b0);
        wr_if.wr_ready = 1'b1;
        push(0, 64'h1, 32'h1234_5678);
        pulse(8'h01);
        check_eq("v0_pba_set",   64'(pba),            64'h01);
        check_eq("v0_not_early", 64'(wr_if.wr_valid), 64'd0);
        tick();
        check_eq("v0_valid", 64'(wr_if.wr_valid), 64'd1);
        check_eq("v0_busy",  64'(busy),           64'd1);
        tick();
        check_eq("v0_done_valid", 64'(wr_if.wr_valid), 64'd0);
        check_eq("v0_pba_clr",    64'(pba),            64'd0);
        tick();
        check_eq("v0_single", 64'(wr_if.wr_valid), 64'd0);

        // Masked vector stays pending; unmasking releases it.
        prog(3, 64'h1000, 32'hA5, 1'b1);
        pulse(8'h08);
        tick();
        tick();
        check_eq("v3_masked_valid", 64'(wr_if.wr_valid), 64'd0);
        check_eq("v3_masked_pba",   64'(pba),            64'h08);
        push(3, 64'h1000, 32'hA5);
        prog(3, 64'h1000, 32'hA5, 1'b0);
        tick();
        check_eq("v3_unmask_valid", 64'(wr_if.wr_valid), 64'd1);
        check_eq("v3_unmask_addr",  wr_if.wr_addr,       64'h1000);
        tick();
        check_eq("v3_pba_clr", 64'(pba), 64'd0);

        // All vectors at once from ptr=0: strict order, one write every 2 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            prog(i, 64'h2000 + 64'(i * 4), 32'h100 + 32'(i), 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            push(i, 64'h2000 + 64'(i * 4), 32'h100 + 32'(i));
        end
        pulse(8'hFF);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("rr_valid_hi", 64'(wr_if.wr_valid), 64'd1);
            check_eq("rr_order",    64'(wr_if.wr_vec),   64'(i));
            tick();
            check_eq("rr_valid_lo", 64'(wr_if.wr_valid), 64'd0);
        end
        check_eq("rr_pba_empty", 64'(pba), 64'd0);

        // Move ptr to 1, then 0 and 5 together must go 5 first.
        push(0, 64'h2000, 32'h100);
        pulse(8'h01);
        tick();
        tick();
        push(5, 64'h2014, 32'h105);
        push(0, 64'h2000, 32'h100);
        pulse(8'h21);
        tick();
        check_eq("wrap_first", 64'(wr_if.wr_vec), 64'd5);
        tick();
        tick();
        check_eq("wrap_second", 64'(wr_if.wr_vec), 64'd0);
        tick();

        // Stalled ISSUE: outputs frozen despite new request and table rewrite.
        prog(2, 64'h3000, 32'h1111, 1'b0);
        wr_if.wr_ready = 1'b0;
        push(2, 64'h3000, 32'h1111);
        pulse(8'h04);
        tick();
        for (int c = 0; c < 10; c++) begin
            intr_req  = (c == 2) ? 8'h04 : 8'h00;
            tbl_wr_en = (c == 4);
            if (c == 4) begin
                tbl_wr_idx  = 3'd2;
                tbl_wr_addr = 64'h3000;
                tbl_wr_data = 32'hBEEF;
                tbl_wr_mask = 1'b0;
            end
            tick();
            tbl_wr_en = 1'b0;
            intr_req  = '0;
            check_eq("stall_valid", 64'(wr_if.wr_valid), 64'd1);
            check_eq("stall_vec",   64'(wr_if.wr_vec),   64'd2);
            check_eq("stall_addr",  wr_if.wr_addr,       64'h3000);
            check_eq("stall_data",  64'(wr_if.wr_data),  64'h1111);
        end
        push(2, 64'h3000, 32'hBEEF);
        wr_if.wr_ready = 1'b1;
        intr_req = 8'h04;
        tick();
        intr_req = '0;
        check_eq("stall_hs_valid", 64'(wr_if.wr_valid), 64'd0);
        check_eq("stall_keep_pba", 64'(pba),            64'h04);
        tick();
        check_eq("stall_2nd_data", 64'(wr_if.wr_data), 64'hBEEF);
        tick();
        check_eq("stall_pba_clr", 64'(pba), 64'd0);

        // Reset mid-ISSUE abandons the write and masks the whole table.
        wr_if.wr_ready = 1'b0;
        pulse(8'h0F);
        tick();
        check_eq("rst_issue_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid_valid", 64'(wr_if.wr_valid), 64'd0);
        check_eq("rst_mid_pba",   64'(pba),            64'd0);
        check_eq("rst_mid_busy",  64'(busy),           64'd0);
        wr_if.wr_ready = 1'b1;
        pulse(8'hFF);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("post_rst_masked", 64'(wr_if.wr_valid), 64'd0);
        end
        check_eq("post_rst_pba", 64'(pba), 64'hFF);

        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_msix_msg_gen

// File: doc/msix_msg_gen.md
# msix_msg_gen

MSI-X message generator: latches per-vector interrupt requests, applies the per-vector mask, and arbitrates among pending vectors round-robin. For the winning vector it issues one posted DW memory write (table address and data) toward the host-memory write path. It is the stage directly upstream of the host interface's DW fill path, so each message lands as a single DW write into host memory. Also exposes the Pending Bit Array (PBA) and a software table-programming port.

## Interface
- NUM_VEC, default 8: number of MSI-X vectors, range 2..32.
- VEC_W, default $clog2(NUM_VEC): vector index width (derived; not overridden).
- clk  in  1: single clock; all logic on posedge.
- rst  in  1: synchronous, active-high reset.
- intr_req  in  NUM_VEC: per-vector request; each cycle high sets that vector's pending bit.
- tbl_wr_en  in  1: table write strobe.
- tbl_wr_idx  in  VEC_W: table entry being written; out-of-range index ignored.
- tbl_wr_addr  in  64: message address for the entry.
- tbl_wr_data  in  32: message data for the entry.
- tbl_wr_mask  in  1: vector mask bit for the entry; 1 = masked.
- wr_valid  out  1: DW write request valid.
- wr_ready  in  1: downstream accepts when wr_valid && wr_ready.
- wr_addr  out  64: DW write address.
- wr_data  out  32: DW write data.
- wr_vec  out  VEC_W: index of the vector being sent (debug and scoreboard).
- pba  out  NUM_VEC: pending bit array, registered.
- busy  out  1: high when the FSM is in ISSUE.

## Operation
- Reset values:
  - All pending bits 0.
  - All table entries: addr 0, data 0, mask 1.
  - Round-robin pointer 0; FSM in IDLE.
  - wr_valid 0, wr_addr 0, wr_data 0, wr_vec 0, busy 0, pba 0.
- Pending: pend[i] <= (pend[i] & ~clr[i]) | intr_req[i]. clr is the one-hot vector handshaked this cycle.
  - A set and a clear on the same vector in the same cycle leaves the bit 1; the new request is not lost.
  - Multiple requests to an already-pending vector coalesce into one message.
- Eligible set = pend & ~mask.
  - A masked vector stays pending and appears in pba.
  - Unmasking a pending vector makes it eligible on the next cycle.
- Arbiter: round-robin. Picks the lowest eligible index at or above ptr, wrapping to 0. After each handshake, ptr <= granted+1, wrapping NUM_VEC-1 -> 0.
- FSM:
  - IDLE: if any vector is eligible, latch table addr/data and the vector index into the output registers, assert wr_valid, go to ISSUE. Otherwise stay.
  - ISSUE: hold wr_valid and the outputs stable until wr_ready. On the handshake, clear that vector's pending bit, deassert wr_valid, advance ptr, return to IDLE.
- Table writes take effect on the next cycle.
  - A write to the entry currently in ISSUE does not change the in-flight wr_addr/wr_data; outputs were latched on entry.
  - Masking an in-flight vector does not cancel it.
- Reset asserted during ISSUE drops wr_valid on the next edge. The transaction is abandoned and all pending state is cleared.

## Timing
- intr_req high at edge N → pba bit visible after N+1 → wr_valid high after N+2 (2-cycle latency from an idle, unmasked state).
- Handshake at edge M → FSM in IDLE after M+1 → the next message's wr_valid is high after M+2. Maximum throughput is one message per 2 cycles.
- wr_valid never drops without a handshake, except on rst.
- wr_ready asserted while wr_valid is low is ignored.

## Structure
- Shared package msix_pkg:
  - msix_entry_t struct: U64 addr, U32 data, bit mask.
  - msix_state_e enum: IDLE, ISSUE.
  - MSIX_MAX_VEC = 32 constant.
  - U32/U64 types reused from misc_pkg.
- Sub-module msix_rr_arb, parameterised by NUM_VEC:
  - Combinational inputs: req[NUM_VEC], ptr.
  - Outputs: gnt_valid, gnt_idx.
  - The top block holds the table, pending bits, FSM and pointer.

## Test plan
- Program vec0: addr 0x1, data 0x12345678, mask 0. Pulse intr_req[0] one cycle with wr_ready=1. Expect exactly one write with wr_addr=0x1 and wr_data=0x12345678 two cycles later; the host side flags MSIX; pba returns to 0.
- Vec3 masked with addr 0x1000, data 0xA5. Pulse intr_req[3]: expect no write and pba[3]=1. Unmask: expect the write (0x1000, 0xA5) within 2 cycles, then pba[3]=0.
- All 8 vectors unmasked, pulse all simultaneously, wr_ready=1: expect writes in order 0,1,…,7, one every 2 cycles; then pulse 0 and 5 with ptr=1: expect order 5 then 0.
- Vec2 in ISSUE with wr_ready held 0 for 10 cycles, pulsing intr_req[2] and rewriting entry 2's data to 0xBEEF meanwhile: outputs stay stable with the old data. On ready, a second write carries 0xBEEF.
- Assert rst mid-ISSUE with 4 vectors pending: the cycle after rst, wr_valid=0, pba=0, busy=0, and all entries read back as masked (no write after any intr_req until reprogrammed).
